multicycle_control: RTL
=======================

# multicycle_control

Moore-style sequencer that turns the single-cycle datapath (PC, instruction memory, register bank, RegDst mux, sign extend, adder) into a multi-cycle MIPS machine sharing one memory port and one ALU. It decodes opcode `instr[31:26]` in DECODE and steps each instruction through fetch, decode, execute, memory and write-back. It drives every datapath select and write enable, and stalls on a memory-ready handshake.

## Interface
- No parameters. State encoding is fixed: 4 bits.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 6: `instr[31:26]` from the instruction register.
- `mem_ready` input 1: memory has completed the current read or write this cycle.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load if ALU zero.
- `iord` output 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `ir_write` output 1: instruction register load.
- `mem_to_reg` output 1: write-back select. 1 = MDR, 0 = ALUOut.
- `reg_dst` output 1: register destination select, drives the RegDst mux `unidadControl`. 1 = `[15:11]`, 0 = `[20:16]`.
- `reg_write` output 1: register bank write enable.
- `alu_src_a` output 1: ALU A select. 0 = PC, 1 = register A.
- `alu_src_b` output 2: ALU B select. 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- `alu_op` output 2: ALU operation. 00 = add, 01 = sub, 10 = funct field.
- `pc_source` output 2: PC source select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` output 1: one-cycle pulse in the final state of every instruction.
- `illegal` output 1: one-cycle pulse in DECODE when the opcode is unsupported.
- `state` output 4: current state, for debug.

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5
  - R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11
- Supported opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=mem_ready and pc_write=mem_ready.
  - Holds until mem_ready=1, then goes to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 to compute the branch target.
  - Next state by opcode: LW/SW→MEM_ADDR, R→R_EXEC, BEQ→BRANCH, J→JUMP, ADDI→ADDI_EXEC.
  - Any other opcode → FETCH with illegal=1.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEM_READ for LW, MEM_WRITE for SW; opcode is sampled live.
- MEM_READ: mem_read=1, iord=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEM_WRITE: mem_write=1, iord=1. Holds until mem_ready. instr_done=mem_ready. Next state FETCH on mem_ready.
- R_EXEC → R_WB:
  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next state FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next state FETCH.
- ADDI_EXEC → ADDI_WB:
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- Any output not listed for a state is 0.
- Unused encodings 12–15 go to FETCH on the next edge and drive all outputs to 0.

## Timing
- On a rising edge with `rst`=1, `state` becomes FETCH.
- While `rst`=1, the following are forced to 0 combinationally: pc_write, pc_write_cond, ir_write, reg_write, mem_write, instr_done, illegal. Select outputs follow FETCH values.
- If `rst` is asserted mid-instruction, the instruction is abandoned. No partial write occurs after the reset edge.
- `mem_ready` is sampled every cycle in FETCH, MEM_READ and MEM_WRITE. Asserting it in any other state has no effect.
- With zero-wait memory (mem_ready held at 1), cycles per instruction are:
  - 4 for R, SW and ADDI
  - 5 for LW
  - 3 for BEQ and J
- Each wait cycle on mem_ready adds exactly one cycle.
- `instr_done` and `illegal` are never high in the same cycle.

## Configuration
- `CTRL_ADDI_EN` defined: ADDI_EXEC and ADDI_WB exist, and ADDI decodes as described above.
- `CTRL_ADDI_EN` undefined:
  - Opcode 001000 is illegal (DECODE→FETCH with illegal=1).
  - Encodings 10 and 11 behave as unused encodings.

## Test plan
- Reset: hold rst=1 for 2 cycles, then release.
  - During reset: state=0, every write enable 0.
  - First cycle after release: mem_read=1, pc_write=1 (mem_ready=1).
- LW (opcode 100011) with mem_ready=1: states 0,1,2,3,4,0 in order. reg_write=1 and mem_to_reg=1 only in state 4.
- SW with mem_ready low for 3 cycles in MEM_WRITE: mem_write stays 1 for 4 cycles, and instr_done pulses on the 4th.
- R-type then BEQ:
  - R-type: reg_dst=1 and alu_op=10 in R_EXEC/R_WB.
  - BEQ: pc_write_cond=1, alu_op=01, pc_source=01 in state 8; 3 cycles total.
- Opcode 111111 → illegal=1 in DECODE, next state 0, no write enable asserted.
- ADDI (001000):
  - With CTRL_ADDI_EN: states 0,1,10,11,0 in order, reg_write=1 in state 11.
  - Without CTRL_ADDI_EN: illegal=1 in DECODE, next state 0.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Moore sequencer for a multi-cycle MIPS datapath (shared memory
//            port and ALU). Optional ADDI support via `CTRL_ADDI_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t w_cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        state_d       = S_FETCH;
        // Under reset the selects present FETCH values; enables are cleared below.
        w_cur         = rst ? S_FETCH : state_q;

        case (w_cur)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    c_OP_LW, c_OP_SW: state_d = S_MEM_ADDR;
                    c_OP_R:           state_d = S_R_EXEC;
                    c_OP_BEQ:         state_d = S_BRANCH;
                    c_OP_J:           state_d = S_JUMP;
`ifdef CTRL_ADDI_EN
                    c_OP_ADDI:        state_d = S_ADDI_EXEC;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == c_OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
`ifdef CTRL_ADDI_EN
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_write     = 1'b0;
            instr_done    = 1'b0;
            illegal       = 1'b0;
        end
    end

endmodule
`default_nettype wire
